// File: rtl/bin_maxpool_pkg.sv
// Shared constants for the binarise + 2x2 max-pool stage that follows the
// binary conv engine.
package bin_maxpool_pkg;

    localparam int DW       = 5;
    localparam int W0       = 26;
    localparam int W1       = 10;
    localparam int MAXW     = 26;
    localparam int LB_DEPTH = MAXW / 2;
    localparam int CW       = 5;
    localparam int LB_AW    = CW - 1;

    localparam int POOL_CNT0 = (W0 / 2) * (W0 / 2);
    localparam int POOL_CNT1 = (W1 / 2) * (W1 / 2);

    // Last column/row index of the frame selected by the layer bit.
    function automatic logic [CW-1:0] last_idx(input logic layer);
        return layer ? CW'(W1 - 1) : CW'(W0 - 1);
    endfunction

endpackage

// File: rtl/bin_maxpool_if.sv
// Stream bundle between the conv engine (master) and the pooling stage (slave).
interface bin_maxpool_if;
    import bin_maxpool_pkg::*;

    logic                 state;
    logic signed [DW-1:0] thresh;
    logic signed [DW-1:0] din;
    logic                 ivalid;
    logic                 idone;
    logic                 dout;
    logic                 ovalid;
    logic                 done;
    logic                 frame_err;

    modport master (
        output state, thresh, din, ivalid, idone,
        input  dout, ovalid, done, frame_err
    );

    modport slave (
        input  state, thresh, din, ivalid, idone,
        output dout, ovalid, done, frame_err
    );

endinterface

// File: rtl/bin_maxpool_pool_line_buf.sv
// One bit per pooled column: holds the OR of the even row's 2x1 pair until the
// odd row completes the 2x2 window.
module pool_line_buf
    import bin_maxpool_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [LB_AW-1:0] idx,
    input  logic             wdata,
    output logic             rdata
);

    logic [LB_DEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (clr) begin
            mem <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/bin_maxpool.sv
// Sign-activation binariser followed by 2x2 / stride-2 OR pooling over the
// conv engine's raster stream; one channel per frame.
module bin_maxpool
    import bin_maxpool_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    bin_maxpool_if.slave  bus
);

    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col_nx;
    logic [CW-1:0]        row_nx;
    logic                 state_q;
    logic signed [DW-1:0] thresh_q;
    logic                 pair;
    logic                 done_pend;
    logic                 dout_q;
    logic                 ovalid_q;
    logic                 done_q;
    logic                 err_q;

    logic                 frame_start;
    logic                 eff_state;
    logic signed [DW-1:0] eff_thresh;
    logic [CW-1:0]        w_last;
    logic                 bit_b;
    logic                 frame_end;
    logic                 abort;
    logic                 lb_we;
    logic                 lb_rd;
    logic [LB_AW-1:0]     lb_idx;

    // The first beat of a frame must already use the values it captures.
    always_comb begin
        frame_start = bus.ivalid && (col == '0) && (row == '0);
        eff_state   = frame_start ? bus.state  : state_q;
        eff_thresh  = frame_start ? bus.thresh : thresh_q;
        w_last      = last_idx(eff_state);
        bit_b       = (bus.din >= eff_thresh);
        lb_idx      = col[CW-1:1];
        lb_we       = bus.ivalid && col[0] && !row[0];
        frame_end   = bus.ivalid && (col == w_last) && (row == w_last);
    end

    always_comb begin
        col_nx = col;
        row_nx = row;
        if (bus.ivalid) begin
            if (col == w_last) begin
                col_nx = '0;
                row_nx = (row == w_last) ? '0 : row + 1'b1;
            end else begin
                col_nx = col + 1'b1;
            end
        end
        // idone is judged on the counters as updated by a coincident beat.
        abort = bus.idone && ((col_nx != '0) || (row_nx != '0));
    end

    pool_line_buf u_line_buf (
        .clk   (clk),
        .clr   (rst),
        .we    (lb_we),
        .idx   (lb_idx),
        .wdata (pair | bit_b),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            state_q   <= 1'b0;
            thresh_q  <= '0;
            pair      <= 1'b0;
            done_pend <= 1'b0;
            dout_q    <= 1'b0;
            ovalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ovalid_q  <= 1'b0;
            done_pend <= 1'b0;
            done_q    <= done_pend;

            if (frame_start) begin
                state_q  <= bus.state;
                thresh_q <= bus.thresh;
            end

            if (bus.ivalid) begin
                if (!col[0]) begin
                    pair <= bit_b;
                end else if (row[0]) begin
                    dout_q   <= lb_rd | pair | bit_b;
                    ovalid_q <= 1'b1;
                end
            end

            col <= col_nx;
            row <= row_nx;

            if (frame_end) begin
                done_pend <= 1'b1;
            end

            if (abort) begin
                col       <= '0;
                row       <= '0;
                pair      <= 1'b0;
                err_q     <= 1'b1;
                done_pend <= 1'b1;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.ovalid    = ovalid_q;
    assign bus.done      = done_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_bin_maxpool.sv
// Scoreboard bench for bin_maxpool: stimulus pushes expected pooled bits and
// done cycles, independent monitors pop and compare.
module tb_bin_maxpool;
    import bin_maxpool_pkg::*;

    typedef struct {
        bit val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t exp_q[$];
    int   done_q[$];

    bin_maxpool_if bus();

    bin_maxpool dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int gen_din(input int pat, input int w, input int r, input int c);
        int k;
        int cyc4[4];
        cyc4[0] = 2; cyc4[1] = 3; cyc4[2] = -4; cyc4[3] = 4;
        k = r * w + c;
        case (pat)
            0: return 9;
            1: return (r == 3 && c == 5) ? 1 : -1;
            2: return cyc4[k % 4];
            3: return (r == c) ? 3 : 2;
            4: return (r == 1 && c == 8) ? 2 : (((r + c) % 3 == 0) ? -3 : -4);
            default: return (((r / 2) + (c / 2)) % 2 == 1) ? 5 : -5;
        endcase
    endfunction

    function automatic bit exp_pool(input int pat, input int w, input int th, input int pr, input int pc);
        bit o = 1'b0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (gen_din(pat, w, 2 * pr + dr, 2 * pc + dc) >= th) o = 1'b1;
        return o;
    endfunction

    task automatic idle(input int n);
        bus.ivalid = 1'b0;
        bus.idone  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives nbeats of a frame; expectations always use the values at frame start.
    task automatic run_frame(input bit st, input int th, input int pat, input bit gaps,
                             input int nbeats, input bit toggle, input bit idone_last);
        int w;
        int r;
        int c;
        int e;
        exp_t x;
        w = st ? W1 : W0;
        for (int k = 0; k < nbeats; k++) begin
            r = k / w;
            c = k % w;
            bus.state  = (toggle && k >= 20) ? ~st : st;
            bus.thresh = (toggle && k >= 20) ? DW'(15) : DW'(th);
            bus.din    = DW'(gen_din(pat, w, r, c));
            bus.ivalid = 1'b1;
            bus.idone  = idone_last && (k == nbeats - 1);
            @(posedge clk);
            #1;
            e = cyc;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                x.val = exp_pool(pat, w, th, r / 2, c / 2);
                x.cyc = e;
                exp_q.push_back(x);
            end
            if (k == w * w - 1) done_q.push_back(e + 1);
            bus.ivalid = 1'b0;
            bus.idone  = 1'b0;
            if (gaps && c == w - 1) idle(2);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ovalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ovalid", 1'b0, 1, 0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("pooled_dout", bus.dout == x.val, int'(bus.dout), int'(x.val));
                    check("ovalid_latency", cyc == x.cyc, cyc, x.cyc);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1'b0, 1, 0);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    check("done_cycle", cyc == d, cyc, d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        bus.state  = 1'b0;
        bus.thresh = '0;
        bus.din    = '0;
        bus.ivalid = 1'b0;
        bus.idone  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_dout", bus.dout == 1'b0, int'(bus.dout), 0);
        check("rst_ovalid", bus.ovalid == 1'b0, int'(bus.ovalid), 0);
        check("rst_done", bus.done == 1'b0, int'(bus.done), 0);
        check("rst_frame_err", bus.frame_err == 1'b0, int'(bus.frame_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Layer 1, all +9; idone alongside the final beat must be ignored.
        run_frame(1'b1, 0, 0, 1'b0, 100, 1'b0, 1'b1);
        idle(4);
        // Layer 0, single +1 at (3,5) -> only pooled (1,2) set.
        run_frame(1'b0, 0, 1, 1'b0, 676, 1'b0, 1'b0);
        idle(4);
        // Same frame with 2-cycle gaps after each row.
        run_frame(1'b0, 0, 1, 1'b1, 676, 1'b0, 1'b0);
        idle(4);
        // Threshold 3 with the {2,3,-4,4} cycle, then 3-vs-2 on the diagonal.
        run_frame(1'b1, 3, 2, 1'b0, 100, 1'b0, 1'b0);
        idle(4);
        run_frame(1'b1, 3, 3, 1'b0, 100, 1'b0, 1'b0);
        idle(4);
        check("err_before_abort", bus.frame_err == 1'b0, int'(bus.frame_err), 0);

        // Partial frame of 37 beats then idone.
        run_frame(1'b1, 0, 0, 1'b0, 37, 1'b0, 1'b0);
        bus.idone = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        bus.idone = 1'b0;
        done_q.push_back(e + 1);
        @(negedge clk);
        check("abort_frame_err", bus.frame_err == 1'b1, int'(bus.frame_err), 1);
        idle(4);
        run_frame(1'b1, 0, 5, 1'b0, 100, 1'b0, 1'b0);
        idle(4);
        check("err_sticky", bus.frame_err == 1'b1, int'(bus.frame_err), 1);

        // Mid-frame changes to state/thresh are ignored; rst after beat 50.
        run_frame(1'b1, 0, 0, 1'b0, 50, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst2_dout", bus.dout == 1'b0, int'(bus.dout), 0);
        check("rst2_ovalid", bus.ovalid == 1'b0, int'(bus.ovalid), 0);
        check("rst2_done", bus.done == 1'b0, int'(bus.done), 0);
        check("rst2_frame_err", bus.frame_err == 1'b0, int'(bus.frame_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.state  = 1'b0;
        bus.thresh = '0;
        idle(6);

        // Fresh frame after rst: signed threshold -3 against -3/-4/+2.
        run_frame(1'b1, -3, 4, 1'b0, 100, 1'b0, 1'b0);
        idle(6);

        check("exp_queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("done_queue_drained", done_q.size() == 0, done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
